// File: rtl/sc_microsequencer.sv
// Microprogrammed sequencer: fetches 41-bit microwords, drives datapath controls.
// Optional memory-wait timeout/trap enabled by SC_MICROSEQ_MEMTIMEOUT_EN.
module sc_microsequencer #(
  parameter int DATAWIDTH_BUS = 32,
  parameter int DATAWIDTH_MICROWORD = 41,
  parameter int DATAWIDTH_CSAR = 11,
  parameter logic [5:0] NOWRITE_CODE = 6'b111111
`ifdef SC_MICROSEQ_MEMTIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 255,
  parameter logic [DATAWIDTH_CSAR-1:0] TRAP_ADDR = 11'h7FF
`endif
) (
  input  logic                           SC_MICROSEQ_CLOCK_50,
  input  logic                           SC_MICROSEQ_RESET_InLow,
  input  logic [DATAWIDTH_BUS-1:0]       SC_MICROSEQ_IR_InBUS,
  input  logic [3:0]                     SC_MICROSEQ_flags_InLow,
  input  logic [DATAWIDTH_MICROWORD-1:0] SC_MICROSEQ_ROMdata_InBUS,
  input  logic                           SC_MICROSEQ_MEMready_InHigh,
  output logic [DATAWIDTH_CSAR-1:0]      SC_MICROSEQ_ROMaddr_OutBUS,
  output logic [5:0]                     SC_MICROSEQ_BUS_CONTROL_A,
  output logic [5:0]                     SC_MICROSEQ_BUS_CONTROL_B,
  output logic [5:0]                     SC_MICROSEQ_BUS_CONTROL_C,
  output logic                           SC_MICROSEQ_BUS_SELECTOR_A,
  output logic                           SC_MICROSEQ_BUS_SELECTOR_B,
  output logic                           SC_MICROSEQ_BUS_SELECTOR_C,
  output logic [3:0]                     SC_MICROSEQ_aluselection_OutBUS,
  output logic                           SC_MICROSEQ_MEMrd_OutHigh,
  output logic                           SC_MICROSEQ_MEMwr_OutHigh,
  output logic                           SC_MICROSEQ_CWRITE_OutLow,
  output logic [3:0]                     SC_MICROSEQ_PSR_OutBUS,
  output logic                           SC_MICROSEQ_error_OutHigh
);

  typedef enum logic [1:0] {
    FETCH,
    EXEC,
    MEMWAIT
  } state_t;

  logic clk;
  logic rstN;
  assign clk  = SC_MICROSEQ_CLOCK_50;
  assign rstN = SC_MICROSEQ_RESET_InLow;

  state_t state;
  state_t stateNext;

  logic [DATAWIDTH_MICROWORD-1:0] mir;
  logic [DATAWIDTH_CSAR-1:0] csar;
  logic [DATAWIDTH_CSAR-1:0] csarNext;
  logic [DATAWIDTH_CSAR-1:0] csarInc;
  logic [DATAWIDTH_CSAR-1:0] branchAddr;
  logic [3:0] psr;
  logic [3:0] psrNext;

  logic [5:0] fieldA;
  logic       fieldAmux;
  logic [5:0] fieldB;
  logic       fieldBmux;
  logic [5:0] fieldC;
  logic       fieldCmux;
  logic       fieldRd;
  logic       fieldWr;
  logic [3:0] fieldAlu;
  logic [2:0] fieldCond;
  logic [10:0] fieldJaddr;

  assign fieldA     = mir[40:35];
  assign fieldAmux  = mir[34];
  assign fieldB     = mir[33:28];
  assign fieldBmux  = mir[27];
  assign fieldC     = mir[26:21];
  assign fieldCmux  = mir[20];
  assign fieldRd    = mir[19];
  assign fieldWr    = mir[18];
  assign fieldAlu   = mir[17:14];
  assign fieldCond  = mir[13:11];
  assign fieldJaddr = mir[10:0];

  logic memOp;
  logic active;
  logic lastCycle;
  logic abort;
  logic takeJump;

  assign memOp   = fieldRd | fieldWr;
  assign active  = (state != FETCH);
  assign csarInc = csar + 1'b1;

  logic unusedIr;
  assign unusedIr = ^{SC_MICROSEQ_IR_InBUS[29:25],
                      SC_MICROSEQ_IR_InBUS[18:14],
                      SC_MICROSEQ_IR_InBUS[12:0]};

`ifdef SC_MICROSEQ_MEMTIMEOUT_EN
  logic [7:0] tmoCnt;
  logic       errReg;
  logic       tmoHit;
  assign tmoHit = (tmoCnt == 8'(TIMEOUT_CYCLES - 1));
`endif

  always_comb begin
    takeJump = 1'b0;
    unique case (fieldCond)
      3'd1: takeJump = psr[3];
      3'd2: takeJump = psr[2];
      3'd3: takeJump = psr[1];
      3'd4: takeJump = psr[0];
      3'd5: takeJump = SC_MICROSEQ_IR_InBUS[13];
      3'd6: takeJump = 1'b1;
      default: takeJump = 1'b0;
    endcase
    if (fieldCond == 3'd7) begin
      branchAddr = {1'b1, SC_MICROSEQ_IR_InBUS[31:30],
                    SC_MICROSEQ_IR_InBUS[24:19], 2'b00};
    end else if (takeJump) begin
      branchAddr = fieldJaddr;
    end else begin
      branchAddr = csarInc;
    end
  end

  always_comb begin
    stateNext = state;
    lastCycle = 1'b0;
    abort     = 1'b0;
    unique case (state)
      FETCH: stateNext = EXEC;
      EXEC: begin
        if (memOp) begin
          stateNext = MEMWAIT;
        end else begin
          stateNext = FETCH;
          lastCycle = 1'b1;
        end
      end
      MEMWAIT: begin
        if (SC_MICROSEQ_MEMready_InHigh) begin
          stateNext = FETCH;
          lastCycle = 1'b1;
        end
`ifdef SC_MICROSEQ_MEMTIMEOUT_EN
        else if (tmoHit) begin
          stateNext = FETCH;
          abort     = 1'b1;
        end
`endif
      end
      default: stateNext = FETCH;
    endcase
  end

  // Branch decision sees the PSR from before this cycle's flag update.
  always_comb begin
    csarNext = csar;
    psrNext  = psr;
    if (lastCycle) begin
      csarNext = branchAddr;
      if (fieldAlu[3:2] == 2'b00) begin
        psrNext = ~SC_MICROSEQ_flags_InLow;
      end
    end
`ifdef SC_MICROSEQ_MEMTIMEOUT_EN
    if (abort) begin
      csarNext = TRAP_ADDR;
    end
`endif
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state <= FETCH;
      mir   <= '0;
      csar  <= '0;
      psr   <= '0;
    end else begin
      state <= stateNext;
      csar  <= csarNext;
      psr   <= psrNext;
      if (state == FETCH) begin
        mir <= SC_MICROSEQ_ROMdata_InBUS;
      end
    end
  end

`ifdef SC_MICROSEQ_MEMTIMEOUT_EN
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      tmoCnt <= '0;
      errReg <= 1'b0;
    end else begin
      if (state == EXEC) begin
        tmoCnt <= '0;
      end else if (state == MEMWAIT) begin
        tmoCnt <= tmoCnt + 8'd1;
      end
      if (abort) begin
        errReg <= 1'b1;
      end
    end
  end
  assign SC_MICROSEQ_error_OutHigh = errReg;
`else
  logic unusedAbort;
  assign unusedAbort = abort;
  assign SC_MICROSEQ_error_OutHigh = 1'b0;
`endif

  assign SC_MICROSEQ_ROMaddr_OutBUS = csar;
  assign SC_MICROSEQ_BUS_CONTROL_A  = active ? fieldA : 6'd0;
  assign SC_MICROSEQ_BUS_CONTROL_B  = active ? fieldB : 6'd0;
  assign SC_MICROSEQ_BUS_CONTROL_C  = active ? fieldC : NOWRITE_CODE;
  assign SC_MICROSEQ_BUS_SELECTOR_A = active & fieldAmux;
  assign SC_MICROSEQ_BUS_SELECTOR_B = active & fieldBmux;
  assign SC_MICROSEQ_BUS_SELECTOR_C = active & fieldCmux;
  assign SC_MICROSEQ_aluselection_OutBUS = active ? fieldAlu : 4'd0;
  assign SC_MICROSEQ_MEMrd_OutHigh  = active & fieldRd;
  assign SC_MICROSEQ_MEMwr_OutHigh  = active & fieldWr & ~fieldRd;
  assign SC_MICROSEQ_CWRITE_OutLow  = ~lastCycle;
  assign SC_MICROSEQ_PSR_OutBUS     = psr;

endmodule

// File: tb/tb_sc_microsequencer.sv
// Directed + randomized bench for sc_microsequencer against a rule-level model.
`timescale 1ns/1ps

`define CHK(tag, obs, exp) \
  begin \
    vectors++; \
    assert ((obs) === (exp)) else begin \
      miscompares++; \
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp); \
    end \
  end

module tb_sc_microsequencer;

  localparam logic [5:0] NOWR = 6'b111111;

  logic        clk = 1'b0;
  logic        rstN;
  logic [31:0] ir;
  logic [3:0]  flagsN;
  logic [40:0] romData;
  logic        ready;
  logic [10:0] romAddr;
  logic [5:0]  ctlA, ctlB, ctlC;
  logic        selA, selB, selC;
  logic [3:0]  alu;
  logic        memRd, memWr, cwrite;
  logic [3:0]  psr;
  logic        err;

  logic [40:0] rom [0:2047];
  assign romData = rom[romAddr];

  int vectors = 0;
  int miscompares = 0;

  logic [10:0] mCsar;
  logic [3:0]  mPsr;
  logic        mErr;

  always #5 clk = ~clk;

  sc_microsequencer dut (
    .SC_MICROSEQ_CLOCK_50(clk),
    .SC_MICROSEQ_RESET_InLow(rstN),
    .SC_MICROSEQ_IR_InBUS(ir),
    .SC_MICROSEQ_flags_InLow(flagsN),
    .SC_MICROSEQ_ROMdata_InBUS(romData),
    .SC_MICROSEQ_MEMready_InHigh(ready),
    .SC_MICROSEQ_ROMaddr_OutBUS(romAddr),
    .SC_MICROSEQ_BUS_CONTROL_A(ctlA),
    .SC_MICROSEQ_BUS_CONTROL_B(ctlB),
    .SC_MICROSEQ_BUS_CONTROL_C(ctlC),
    .SC_MICROSEQ_BUS_SELECTOR_A(selA),
    .SC_MICROSEQ_BUS_SELECTOR_B(selB),
    .SC_MICROSEQ_BUS_SELECTOR_C(selC),
    .SC_MICROSEQ_aluselection_OutBUS(alu),
    .SC_MICROSEQ_MEMrd_OutHigh(memRd),
    .SC_MICROSEQ_MEMwr_OutHigh(memWr),
    .SC_MICROSEQ_CWRITE_OutLow(cwrite),
    .SC_MICROSEQ_PSR_OutBUS(psr),
    .SC_MICROSEQ_error_OutHigh(err)
  );

  function automatic logic [10:0] refNext(
    input logic [40:0] w,
    input logic [10:0] a,
    input logic [3:0]  p,
    input logic [31:0] x
  );
    int c;
    logic [10:0] inc;
    logic [10:0] j;
    c   = int'(w[13:11]);
    j   = w[10:0];
    inc = 11'((int'(a) + 1) % 2048);
    case (c)
      0: return inc;
      1: return p[3] ? j : inc;
      2: return p[2] ? j : inc;
      3: return p[1] ? j : inc;
      4: return p[0] ? j : inc;
      5: return x[13] ? j : inc;
      6: return j;
      default: return {1'b1, x[31:30], x[24:19], 2'b00};
    endcase
  endfunction

  function automatic logic [40:0] mk(
    input logic rd,
    input logic wr,
    input logic [3:0] op,
    input logic [2:0] cond,
    input logic [10:0] ja
  );
    logic [20:0] regs;
    regs = 21'($urandom());
    return {regs, rd, wr, op, cond, ja};
  endfunction

  task automatic checkIdle(input string tag);
    `CHK({tag, "_addr"}, romAddr, mCsar)
    `CHK({tag, "_cwrite"}, cwrite, 1'b1)
    `CHK({tag, "_ctlc"}, ctlC, NOWR)
    `CHK({tag, "_ctlab"}, {ctlA, ctlB, selA, selB, selC, alu}, 20'd0)
    `CHK({tag, "_strobes"}, {memRd, memWr}, 2'b00)
    `CHK({tag, "_psr"}, psr, mPsr)
    `CHK({tag, "_err"}, err, mErr)
  endtask

  task automatic checkCtl(input logic [40:0] w, input bit last);
    `CHK("ctl_fields", {ctlA, selA, ctlB, selB, ctlC, selC, alu},
         {w[40:20], w[17:14]})
    `CHK("ctl_rd", memRd, w[19])
    `CHK("ctl_wr", memWr, w[18] & ~w[19])
    `CHK("ctl_cwrite", cwrite, !last)
    `CHK("ctl_addr", romAddr, mCsar)
  endtask

  task automatic runWord(
    input logic [3:0]  fl,
    input logic [31:0] irv,
    input int          readyAt
  );
    logic [40:0] w;
    bit mem;
    w = rom[mCsar];
    mem = w[19] | w[18];
    ready = 1'($urandom());
    flagsN = 4'($urandom());
    #1;
    checkIdle("fetch");
    @(posedge clk); #1;
    ir = irv;
    ready = 1'($urandom());
    flagsN = mem ? 4'($urandom()) : fl;
    #1;
    checkCtl(w, !mem);
    for (int i = 1; mem && i <= readyAt; i++) begin
      @(posedge clk); #1;
      ready = (i == readyAt);
      flagsN = (i == readyAt) ? fl : 4'($urandom());
      #1;
      checkCtl(w, i == readyAt);
    end
    mCsar = refNext(w, mCsar, mPsr, irv);
    if (w[17:16] == 2'b00) mPsr = ~fl;
    @(posedge clk); #1;
    ready = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) rom[i] = '0;
    rstN = 1'b0;
    ir = '0;
    flagsN = 4'hF;
    ready = 1'b0;
    mCsar = '0;
    mPsr = '0;
    mErr = 1'b0;
    #2;
    checkIdle("reset");
    @(posedge clk);
    @(posedge clk); #1;
    rstN = 1'b1;

    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (romAddr !== 11'(i)) begin
        miscompares++;
        $error("FAIL zero_seq_addr observed=%h expected=%h",
               romAddr, 11'(i));
      end
      runWord(4'($urandom()), $urandom(), 1);
    end

    rom[3] = mk(1'b0, 1'b0, 4'b0011, 3'd0, 11'h000);
    rom[4] = mk(1'b0, 1'b0, 4'b0100, 3'd2, 11'h100);
    runWord(4'b1011, $urandom(), 1);
    vectors++;
    if (psr !== 4'b0100) begin
      miscompares++;
      $error("FAIL psr_addcc observed=%h expected=%h", psr, 4'b0100);
    end
    runWord(4'($urandom()), $urandom(), 1);
    vectors++;
    if (romAddr !== 11'h100) begin
      miscompares++;
      $error("FAIL cond2_jump observed=%h expected=%h",
             romAddr, 11'h100);
    end

    rom[11'h100] = mk(1'b0, 1'b0, 4'b0100, 3'd7, 11'h000);
    runWord(4'($urandom()), 32'h8080_0000, 1);
    `CHK("cond7_addr", romAddr, 11'h640)

    rom[11'h640] = mk(1'b1, 1'b1, 4'b0100, 3'd6, 11'h7FF);
    runWord(4'($urandom()), $urandom(), 3);
    `CHK("mem_jump", romAddr, 11'h7FF)

    rom[11'h7FF] = mk(1'b0, 1'b0, 4'b1000, 3'd0, 11'h123);
    runWord(4'($urandom()), $urandom(), 1);
    vectors++;
    if (romAddr !== 11'h000) begin
      miscompares++;
      $error("FAIL wrap_addr observed=%h expected=%h",
             romAddr, 11'h000);
    end

    for (int i = 0; i < 2048; i++) rom[i] = 41'({$urandom(), $urandom()});
    for (int n = 0; n < 400; n++) begin
      runWord(4'($urandom()), $urandom(), int'($urandom_range(1, 4)));
      vectors++;
      if (romAddr !== mCsar) begin
        miscompares++;
        $error("FAIL rand_addr observed=%h expected=%h",
               romAddr, mCsar);
      end
    end

`ifdef SC_MICROSEQ_MEMTIMEOUT_EN
    rom[mCsar] = mk(1'b1, 1'b0, 4'b0000, 3'd6, 11'h123);
    #1;
    checkIdle("tmo_fetch");
    @(posedge clk); #1;
    ready = 1'b0;
    #1;
    checkCtl(rom[mCsar], 1'b0);
    for (int i = 1; i <= 255; i++) begin
      @(posedge clk); #1;
      ready = 1'b0;
      #1;
      if (i == 1 || i == 254 || i == 255) begin
        checkCtl(rom[mCsar], 1'b0);
        `CHK("tmo_err_pending", err, 1'b0)
      end
    end
    @(posedge clk); #1;
    mCsar = 11'h7FF;
    mErr = 1'b1;
    `CHK("tmo_trap_addr", romAddr, 11'h7FF)
    `CHK("tmo_error", err, 1'b1)
    rom[11'h7FF] = mk(1'b0, 1'b0, 4'b0100, 3'd0, 11'h000);
    runWord(4'($urandom()), $urandom(), 1);
    `CHK("tmo_error_sticky", err, 1'b1)
`endif

    rom[mCsar] = mk(1'b0, 1'b0, 4'b0000, 3'd0, 11'h000);
    runWord(4'b0000, $urandom(), 1);
    `CHK("psr_all_set", psr, 4'b1111)
    rom[mCsar] = mk(1'b1, 1'b0, 4'b0000, 3'd6, 11'h2AA);
    @(posedge clk); #1;
    @(posedge clk); #1;
    ready = 1'b0;
    #1;
    `CHK("pre_reset_rd", memRd, 1'b1)
    #2;
    rstN = 1'b0;
    #1;
    mCsar = '0;
    mPsr = '0;
    mErr = 1'b0;
    checkIdle("async_reset");
    @(posedge clk); #1;
    rstN = 1'b1;
    rom[0] = mk(1'b0, 1'b0, 4'b1100, 3'd6, 11'h055);
    runWord(4'($urandom()), $urandom(), 1);
    `CHK("post_reset_jump", romAddr, 11'h055)

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
